// File: rtl/wave_gen.sv
// Periodic waveform sample generator producing 24-bit SPI DAC command words over a valid/ready handshake.
// Optional macro WAVE_GEN_TRI_EN adds the triangle generator; without it MODE=10 falls back to saw.
module wave_gen #(
  parameter int unsigned RATE_DIV = 100,
  parameter logic [3:0]  DAC_CMD  = 4'b0011
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        EN,
  input  logic [1:0]  MODE,
  input  logic [11:0] STEP,
  input  logic [11:0] LEVEL,
  input  logic [3:0]  CH,
  output logic [23:0] CMD_DATA,
  output logic        CMD_VALID,
  input  logic        CMD_READY,
  input  logic        OVR_CLR,
  output logic        OVERRUN
);

  localparam int unsigned DIV_W  = 16;
  localparam int unsigned PH_W   = 12;
  localparam int unsigned WORD_W = 24;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RATE_DIV - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    SEND = 2'd2
  } state_e;

  state_e              state_q;
  logic [DIV_W-1:0]    div_q;
  logic [PH_W-1:0]     phase_q;
  logic [WORD_W-1:0]   data_q;
  logic                valid_q;
  logic                ovr_q;

  logic [PH_W-1:0]     sample_c;
  logic [WORD_W-1:0]   word_c;
  logic [DIV_W-1:0]    div_nxt_c;
  logic                tick_c;
  logic                accept_c;

  // Sample value from the current (pre-increment) phase
  always_comb begin
    sample_c = phase_q;
    case (MODE)
      2'b01: sample_c = {PH_W{phase_q[PH_W-1]}};
`ifdef WAVE_GEN_TRI_EN
      2'b10: sample_c = phase_q[PH_W-1] ? {~phase_q[PH_W-2:0], 1'b0}
                                        : { phase_q[PH_W-2:0], 1'b0};
`else
      2'b10: sample_c = phase_q;
`endif
      2'b11: sample_c = LEVEL;
      default: sample_c = phase_q;
    endcase
  end

  assign word_c    = {DAC_CMD, CH, sample_c, 4'b0000};
  assign div_nxt_c = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
  assign tick_c    = EN && (state_q != IDLE) && (div_q == DIV_LAST);
  assign accept_c  = valid_q && CMD_READY;

  // Control FSM, divider, phase accumulator and output word register
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      div_q   <= '0;
      phase_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          div_q   <= '0;
          phase_q <= '0;
          if (EN) state_q <= RUN;
        end
        RUN: begin
          if (!EN) begin
            state_q <= IDLE;
            div_q   <= '0;
            phase_q <= '0;
          end else begin
            div_q <= div_nxt_c;
            if (tick_c) begin
              data_q  <= word_c;
              valid_q <= 1'b1;
              phase_q <= phase_q + STEP;
              state_q <= SEND;
            end
          end
        end
        SEND: begin
          div_q <= div_nxt_c;
          if (tick_c) begin
            // A tick while a word is pending either replaces it (if accepted) or is dropped
            phase_q <= phase_q + STEP;
            if (accept_c) data_q <= word_c;
          end else if (accept_c) begin
            valid_q <= 1'b0;
            if (EN) begin
              state_q <= RUN;
            end else begin
              state_q <= IDLE;
              div_q   <= '0;
              phase_q <= '0;
            end
          end
        end
        default: state_q <= IDLE;
      endcase

      if (tick_c && (state_q == SEND) && !accept_c) ovr_q <= 1'b1;
      else if (OVR_CLR)                               ovr_q <= 1'b0;
    end
  end

  assign CMD_DATA  = data_q;
  assign CMD_VALID = valid_q;
  assign OVERRUN   = ovr_q;

endmodule

// File: tb/tb_wave_gen.sv
// Directed self-checking bench for wave_gen (RATE_DIV=10); honours WAVE_GEN_TRI_EN for triangle expectations.
module tb_wave_gen;

  localparam int unsigned RDIV = 10;

  logic        clk;
  logic        rst;
  logic        en;
  logic [1:0]  mode;
  logic [11:0] step_v;
  logic [11:0] level;
  logic [3:0]  ch;
  logic [23:0] cmd_data;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        ovr_clr;
  logic        overrun;

  int checks = 0;
  int errors = 0;

  wave_gen #(.RATE_DIV(RDIV), .DAC_CMD(4'b0011)) dut (
    .CLK      (clk),
    .RST      (rst),
    .EN       (en),
    .MODE     (mode),
    .STEP     (step_v),
    .LEVEL    (level),
    .CH       (ch),
    .CMD_DATA (cmd_data),
    .CMD_VALID(cmd_valid),
    .CMD_READY(cmd_ready),
    .OVR_CLR  (ovr_clr),
    .OVERRUN  (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [23:0] got, input logic [23:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  function automatic logic [23:0] word(input logic [3:0] c, input logic [11:0] s);
    return {4'h3, c, s, 4'h0};
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Wait (bounded) for CMD_VALID; check latency in edges when lat != 0, then the word
  task automatic next_word(input string tag, input logic [11:0] s, input int lat);
    int  n;
    bit  got;
    n   = 0;
    got = 1'b0;
    while (n < 40 && !got) begin
      @(posedge clk);
      #1;
      n++;
      if (cmd_valid === 1'b1) got = 1'b1;
    end
    chk({tag, "_seen"}, 24'(got), 24'd1);
    if (lat != 0) chk({tag, "_lat"}, 24'(n), 24'(lat));
    chk({tag, "_data"}, cmd_data, word(ch, s));
  endtask

  // Return to IDLE (draining any pending word) and re-enable
  task automatic restart();
    cmd_ready = 1'b1;
    en        = 1'b0;
    step(2);
    en        = 1'b1;
  endtask

  logic [11:0] tri_exp [4];
  logic [11:0] sq_exp  [4];
  bit          seen;

  initial begin
    rst = 1'b1; en = 1'b0; mode = 2'b00; step_v = 12'h100; level = 12'h000;
    ch = 4'h0; cmd_ready = 1'b1; ovr_clr = 1'b0;
    step(2);
    rst = 1'b0;

    // Reset state and idle with EN low
    for (int i = 0; i < 50; i++) begin
      chk("idle_outs", {cmd_valid, overrun, cmd_data[21:0]}, 24'h0);
      if (cmd_data[23:22] != 2'b00) chk("idle_data_hi", cmd_data, 24'h0);
      step(1);
    end

    // Saw, STEP=0x100, ready tied high
    mode = 2'b00; step_v = 12'h100; ch = 4'h0;
    restart();
    for (int i = 0; i < 5; i++)
      next_word("saw100", 12'(i * 12'h100), (i == 0) ? int'(RDIV + 1) : int'(RDIV));

    // Saw, STEP=0x0F0: wraps FF0 -> 0E0
    step_v = 12'h0F0;
    restart();
    for (int i = 0; i < 19; i++)
      next_word("saw0f0", 12'(i * 12'h0F0), (i == 0) ? int'(RDIV + 1) : int'(RDIV));

    // MODE=10, STEP=0x400
`ifdef WAVE_GEN_TRI_EN
    tri_exp[0] = 12'h000; tri_exp[1] = 12'h800; tri_exp[2] = 12'hFFE; tri_exp[3] = 12'h7FE;
`else
    tri_exp[0] = 12'h000; tri_exp[1] = 12'h400; tri_exp[2] = 12'h800; tri_exp[3] = 12'hC00;
`endif
    mode = 2'b10; step_v = 12'h400; ch = 4'h5;
    restart();
    for (int i = 0; i < 4; i++)
      next_word("tri", tri_exp[i], (i == 0) ? int'(RDIV + 1) : int'(RDIV));

    // Square, STEP=0x400
    sq_exp[0] = 12'h000; sq_exp[1] = 12'h000; sq_exp[2] = 12'hFFF; sq_exp[3] = 12'hFFF;
    mode = 2'b01; ch = 4'hF;
    restart();
    for (int i = 0; i < 4; i++)
      next_word("square", sq_exp[i], (i == 0) ? int'(RDIV + 1) : int'(RDIV));

    // Constant level
    mode = 2'b11; level = 12'hABC; ch = 4'h9;
    restart();
    next_word("const0", 12'hABC, int'(RDIV + 1));
    next_word("const1", 12'hABC, int'(RDIV));

    // Overrun: ready low across two ticks
    mode = 2'b00; step_v = 12'h100; ch = 4'h0;
    restart();
    cmd_ready = 1'b0;
    next_word("ovr_first", 12'h000, int'(RDIV + 1));
    for (int i = 1; i <= int'(RDIV); i++) begin
      step(1);
      chk("ovr_hold_valid", 24'(cmd_valid), 24'd1);
      chk("ovr_hold_data", cmd_data, word(4'h0, 12'h000));
      if (i == int'(RDIV) - 1) chk("ovr_before_tick2", 24'(overrun), 24'd0);
    end
    chk("ovr_after_tick2", 24'(overrun), 24'd1);
    ovr_clr = 1'b1;
    step(1);
    ovr_clr = 1'b0;
    chk("ovr_cleared", 24'(overrun), 24'd0);
    cmd_ready = 1'b1;
    next_word("ovr_resume", 12'h200, int'(RDIV) - 1);

    // Acceptance coincident with a tick
    cmd_ready = 1'b0;
    for (int i = 0; i < int'(RDIV) - 1; i++) begin
      step(1);
      chk("coinc_hold_valid", 24'(cmd_valid), 24'd1);
    end
    cmd_ready = 1'b1;
    step(1);
    cmd_ready = 1'b0;
    chk("coinc_valid", 24'(cmd_valid), 24'd1);
    chk("coinc_data", cmd_data, word(4'h0, 12'h300));
    chk("coinc_no_ovr", 24'(overrun), 24'd0);
    cmd_ready = 1'b1;
    step(1);
    cmd_ready = 1'b0;
    chk("coinc_drained", 24'(cmd_valid), 24'd0);

    // EN drops with a word pending; accepted 5 cycles later, then idle
    next_word("endrop_word", 12'h400, 0);
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step(1);
      chk("endrop_hold_valid", 24'(cmd_valid), 24'd1);
      chk("endrop_hold_data", cmd_data, word(4'h0, 12'h400));
    end
    cmd_ready = 1'b1;
    step(1);
    chk("endrop_accepted", 24'(cmd_valid), 24'd0);
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      step(1);
      if (cmd_valid !== 1'b0) seen = 1'b1;
    end
    chk("endrop_no_more_valid", 24'(seen), 24'd0);

    // Reset mid-SEND with overrun set
    ch = 4'hA;
    restart();
    cmd_ready = 1'b0;
    next_word("rst_word", 12'h000, int'(RDIV + 1));
    step(int'(RDIV));
    chk("rst_pre_ovr", 24'(overrun), 24'd1);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    chk("rst_valid", 24'(cmd_valid), 24'd0);
    chk("rst_data", cmd_data, 24'h0);
    chk("rst_ovr", 24'(overrun), 24'd0);
    cmd_ready = 1'b1;
    next_word("rst_restart", 12'h000, int'(RDIV + 1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
